// File: rtl/dram_arb_pkg.sv
// Shared widths, request record and round-robin pick function for the DRAM arbiter.
package dram_arb_pkg;

    localparam int unsigned DRAM_ADDR_W = 27;
    localparam int unsigned DRAM_DATA_W = 128;
    localparam int unsigned DRAM_MASK_W = 16;

    typedef struct packed {
        logic [DRAM_ADDR_W-1:0] addr;
        logic                   write;
        logic [DRAM_DATA_W-1:0] wdata;
        logic [DRAM_MASK_W-1:0] mask;
    } dram_req_t;

    // One-hot grant of the first set bit of valid, searching ptr, ptr+1, ... modulo n (n <= 8).
    function automatic logic [7:0] rr_pick(input logic [7:0] valid, input logic [2:0] ptr,
                                           input int unsigned n);
        logic [7:0]  grant;
        int unsigned idx;
        grant = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = (32'(ptr) + i) % n;
            if (i < n && grant == '0 && valid[idx[2:0]]) begin
                grant[idx[2:0]] = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/dram_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding DRAM reads.
module dram_arb_tag_fifo #(
    parameter int unsigned W     = 1,
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rp];
    // A push into a full FIFO is only legal when the head is popped in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (w_do_pop && !w_do_push) r_count <= r_count - 1'b1;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// CH-channel round-robin arbiter with one request stage and in-order read-return routing.
// Optional per-channel grant counters are built when DRAM_ARBITER_STATS_EN is defined.
module dram_arbiter
    import dram_arb_pkg::*;
#(
    parameter int unsigned CH        = 2,
    parameter int unsigned ADDR_W    = DRAM_ADDR_W,
    parameter int unsigned DATA_W    = DRAM_DATA_W,
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       sdram_init_busy,
    input  logic [CH*ADDR_W-1:0]       ch_address,
    input  logic [CH-1:0]              ch_write,
    input  logic [CH-1:0]              ch_valid,
    output logic [CH-1:0]              ch_ready,
    input  logic [CH*DATA_W-1:0]       ch_wdata,
    input  logic [CH*(DATA_W/8)-1:0]   ch_wdata_mask,
    output logic [DATA_W-1:0]          ch_rdata,
    output logic [CH-1:0]              ch_rdata_valid,
    output logic [ADDR_W-1:0]          dram_address,
    output logic                       dram_write,
    output logic                       dram_valid,
    input  logic                       dram_ready,
    output logic [DATA_W-1:0]          dram_wdata,
    output logic [DATA_W/8-1:0]        dram_wdata_mask,
    input  logic [DATA_W-1:0]          dram_rdata,
    input  logic                       dram_rdata_valid,
    output logic                       err_orphan,
    output logic [CH*16-1:0]           stat_req_count
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned IDW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int unsigned CW     = $clog2(TAG_DEPTH) + 1;

    logic              r_stage_valid;
    logic [ADDR_W-1:0] r_addr;
    logic              r_write;
    logic [DATA_W-1:0] r_wdata;
    logic [MASK_W-1:0] r_mask;
    logic [IDW-1:0]    r_stage_ch;
    logic [IDW-1:0]    r_ptr;
    logic [DATA_W-1:0] r_rdata;
    logic [CH-1:0]     r_rdata_valid;
    logic              r_orphan;

    logic              w_grant_en;
    logic              w_read_block;
    logic [CH-1:0]     w_elig;
    logic [CH-1:0]     w_grant;
    logic [IDW-1:0]    w_sel;
    logic [ADDR_W-1:0] w_addr;
    logic              w_wr;
    logic [DATA_W-1:0] w_wdata;
    logic [MASK_W-1:0] w_mask;
    logic              w_push;
    logic              w_pop;
    logic [IDW-1:0]    w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CH-1:0]     w_rv_next;

    // A read granted now reaches the FIFO while the staged read (if any) is already counted,
    // so reserve its slot here; the handshake then can never push into a full FIFO.
    assign w_read_block = w_full ||
                          (r_stage_valid && !r_write && (32'(w_count) == TAG_DEPTH - 1));
    assign w_grant_en   = ~reset & ~sdram_init_busy & (~r_stage_valid | dram_ready);
    assign w_elig       = ch_valid & (ch_write | {CH{~w_read_block}});
    assign w_grant      = w_grant_en ? CH'(rr_pick(8'(w_elig), 3'(r_ptr), CH)) : '0;

    always_comb begin
        w_sel   = '0;
        w_addr  = '0;
        w_wr    = 1'b0;
        w_wdata = '0;
        w_mask  = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (w_grant[i]) begin
                w_sel   = IDW'(i);
                w_addr  = ch_address[i*ADDR_W +: ADDR_W];
                w_wr    = ch_write[i];
                w_wdata = ch_wdata[i*DATA_W +: DATA_W];
                w_mask  = ch_wdata_mask[i*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_addr        <= '0;
            r_write       <= 1'b0;
            r_wdata       <= '0;
            r_mask        <= '0;
            r_stage_ch    <= '0;
            r_ptr         <= '0;
        end else if (|w_grant) begin
            r_stage_valid <= 1'b1;
            r_addr        <= w_addr;
            r_write       <= w_wr;
            r_wdata       <= w_wdata;
            r_mask        <= w_mask;
            r_stage_ch    <= w_sel;
            r_ptr         <= IDW'((32'(w_sel) + 1) % CH);
        end else if (dram_ready) begin
            r_stage_valid <= 1'b0;
        end
    end

    assign w_push = r_stage_valid & dram_ready & ~r_write;
    assign w_pop  = dram_rdata_valid & ~w_empty;

    dram_arb_tag_fifo #(
        .W     (IDW),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .din   (r_stage_ch),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_comb begin
        w_rv_next = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_rv_next[i] = w_pop && (w_head == IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata       <= '0;
            r_rdata_valid <= '0;
            r_orphan      <= 1'b0;
        end else begin
            r_rdata_valid <= w_rv_next;
            if (w_pop) r_rdata <= dram_rdata;
            if (dram_rdata_valid && w_empty) r_orphan <= 1'b1;
        end
    end

`ifdef DRAM_ARBITER_STATS_EN
    logic [CH*16-1:0] r_stat;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat <= '0;
        end else begin
            for (int unsigned i = 0; i < CH; i++) begin
                if (w_grant[i] && r_stat[i*16 +: 16] != 16'hFFFF) begin
                    r_stat[i*16 +: 16] <= r_stat[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
    assign stat_req_count = r_stat;
`else
    assign stat_req_count = '0;
`endif

    assign ch_ready        = w_grant;
    assign ch_rdata        = r_rdata;
    assign ch_rdata_valid  = r_rdata_valid;
    assign dram_address    = r_addr;
    assign dram_write      = r_write;
    assign dram_valid      = r_stage_valid;
    assign dram_wdata      = r_wdata;
    assign dram_wdata_mask = r_mask;
    assign err_orphan      = r_orphan;

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter (CH=2, TAG_DEPTH=8).
module tb_dram_arbiter;

    localparam logic [26:0]  A0    = 27'h1000100;
    localparam logic [26:0]  A1    = 27'h2345678;
    localparam logic [127:0] W0    = 128'h0123_4567_89AB_CDEF_1111_2222_3333_4444;
    localparam logic [127:0] W1    = 128'hFEDC_BA98_7654_3210_5555_6666_7777_8888;
    localparam logic [15:0]  M0    = 16'h000F;
    localparam logic [15:0]  M1    = 16'hF0F0;
    localparam logic [127:0] RBASE = 128'hC0DE_0000_0000_0000_0000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         sdram_init_busy;
    logic [53:0]  ch_address;
    logic [1:0]   ch_write;
    logic [1:0]   ch_valid;
    logic [1:0]   ch_ready;
    logic [255:0] ch_wdata;
    logic [31:0]  ch_wdata_mask;
    logic [127:0] ch_rdata;
    logic [1:0]   ch_rdata_valid;
    logic [26:0]  dram_address;
    logic         dram_write;
    logic         dram_valid;
    logic         dram_ready;
    logic [127:0] dram_wdata;
    logic [15:0]  dram_wdata_mask;
    logic [127:0] dram_rdata;
    logic         dram_rdata_valid;
    logic         err_orphan;
    logic [31:0]  stat_req_count;

    int errors = 0;
    int checks = 0;

    dram_arbiter #(
        .CH        (2),
        .ADDR_W    (27),
        .DATA_W    (128),
        .TAG_DEPTH (8)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .sdram_init_busy  (sdram_init_busy),
        .ch_address       (ch_address),
        .ch_write         (ch_write),
        .ch_valid         (ch_valid),
        .ch_ready         (ch_ready),
        .ch_wdata         (ch_wdata),
        .ch_wdata_mask    (ch_wdata_mask),
        .ch_rdata         (ch_rdata),
        .ch_rdata_valid   (ch_rdata_valid),
        .dram_address     (dram_address),
        .dram_write       (dram_write),
        .dram_valid       (dram_valid),
        .dram_ready       (dram_ready),
        .dram_wdata       (dram_wdata),
        .dram_wdata_mask  (dram_wdata_mask),
        .dram_rdata       (dram_rdata),
        .dram_rdata_valid (dram_rdata_valid),
        .err_orphan       (err_orphan),
        .stat_req_count   (stat_req_count)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_valid = 2'b11; ch_write = 2'b11; dram_ready = 1'b1;
        repeat (3) cyc();
        checks++;
        if (ch_ready !== 2'b00 || dram_valid !== 1'b0 || dram_address !== '0 || dram_write !== 1'b0 ||
            dram_wdata !== '0 || dram_wdata_mask !== '0 || ch_rdata !== '0 ||
            ch_rdata_valid !== 2'b00 || err_orphan !== 1'b0 || stat_req_count !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b dvalid=%b addr=%h rvalid=%b orphan=%b stat=%h, all required 0",
                     ch_ready, dram_valid, dram_address, ch_rdata_valid, err_orphan, stat_req_count);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 2'b01) begin
            errors++; $display("FAIL reset_first_grant: ch_ready=%b required 01", ch_ready);
        end
        cyc();
        checks++;
        if (dram_valid !== 1'b1 || dram_address !== A0 || dram_write !== 1'b1 || ch_ready !== 2'b10) begin
            errors++;
            $display("FAIL reset_stage_latency: dvalid=%b addr=%h wr=%b ready=%b required 1 %h 1 10",
                     dram_valid, dram_address, dram_write, ch_ready, A0);
        end
        cyc();
        ch_valid = 2'b00;
        #1;
        checks++;
        if (dram_address !== A1 || ch_ready !== 2'b00) begin
            errors++; $display("FAIL reset_second_grant: addr=%h ready=%b required %h 00", dram_address, ch_ready, A1);
        end
        cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g [4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        ch_write = 2'b00; ch_valid = 2'b11; dram_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++;
            if (ch_ready !== exp_g[k]) begin
                errors++; $display("FAIL rr_grant[%0d]: ch_ready=%b required %b", k, ch_ready, exp_g[k]);
            end
            if (k > 0) begin
                checks++;
                if (dram_valid !== 1'b1 || dram_write !== 1'b0 ||
                    dram_address !== ((exp_g[k-1] == 2'b01) ? A0 : A1)) begin
                    errors++;
                    $display("FAIL rr_stage[%0d]: dvalid=%b wr=%b addr=%h required 1 0 %h", k, dram_valid,
                             dram_write, dram_address, (exp_g[k-1] == 2'b01) ? A0 : A1);
                end
            end
            cyc();
        end
        ch_valid = 2'b00;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) begin
                dram_rdata_valid = 1'b1; dram_rdata = RBASE + 128'(k);
            end else begin
                dram_rdata_valid = 1'b0;
            end
            cyc();
            if (k < 4) begin
                checks++;
                if (ch_rdata_valid !== exp_g[k] || ch_rdata !== RBASE + 128'(k)) begin
                    errors++;
                    $display("FAIL rr_return[%0d]: rvalid=%b data=%h required %b %h", k, ch_rdata_valid,
                             ch_rdata, exp_g[k], RBASE + 128'(k));
                end
            end else begin
                checks++;
                if (ch_rdata_valid !== 2'b00) begin
                    errors++; $display("FAIL rr_return_idle: rvalid=%b required 00", ch_rdata_valid);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        ch_write = 2'b11; ch_valid = 2'b11; dram_ready = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 2'b01) begin
            errors++; $display("FAIL bp_first_grant: ch_ready=%b required 01", ch_ready);
        end
        cyc();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (ch_ready !== 2'b00 || dram_valid !== 1'b1 || dram_address !== A0 || dram_write !== 1'b1 ||
                dram_wdata !== W0 || dram_wdata_mask !== M0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: ready=%b dvalid=%b addr=%h wd=%h mask=%h required 00 1 %h %h %h",
                         k, ch_ready, dram_valid, dram_address, dram_wdata, dram_wdata_mask, A0, W0, M0);
            end
            cyc();
        end
        dram_ready = 1'b1;
        #1;
        checks++;
        if (ch_ready !== 2'b10) begin
            errors++; $display("FAIL bp_release_grant: ch_ready=%b required 10", ch_ready);
        end
        cyc();
        ch_valid = 2'b00;
        #1;
        checks++;
        if (dram_valid !== 1'b1 || dram_address !== A1 || dram_wdata !== W1 || dram_wdata_mask !== M1) begin
            errors++;
            $display("FAIL bp_next_stage: dvalid=%b addr=%h wd=%h mask=%h required 1 %h %h %h",
                     dram_valid, dram_address, dram_wdata, dram_wdata_mask, A1, W1, M1);
        end
        cyc();
        checks++;
        if (dram_valid !== 1'b0) begin
            errors++; $display("FAIL bp_drain: dvalid=%b required 0", dram_valid);
        end
    endtask

    task automatic test_tag_full();
        ch_write = 2'b00; ch_valid = 2'b01; dram_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            checks++;
            if (ch_ready !== 2'b01) begin
                errors++; $display("FAIL tag_fill[%0d]: ch_ready=%b required 01", k, ch_ready);
            end
            cyc();
        end
        #1;
        checks++;
        if (ch_ready !== 2'b00) begin
            errors++; $display("FAIL tag_ninth_read: ch_ready=%b required 00", ch_ready);
        end
        ch_valid = 2'b11; ch_write = 2'b10;
        #1;
        checks++;
        if (ch_ready !== 2'b10) begin
            errors++; $display("FAIL tag_write_bypass: ch_ready=%b required 10", ch_ready);
        end
        cyc();
        ch_valid = 2'b01;
        #1;
        checks++;
        if (ch_ready !== 2'b00) begin
            errors++; $display("FAIL tag_full_hold: ch_ready=%b required 00", ch_ready);
        end
        cyc();
        checks++;
        if (ch_ready !== 2'b00) begin
            errors++; $display("FAIL tag_full_hold2: ch_ready=%b required 00", ch_ready);
        end
        dram_rdata_valid = 1'b1; dram_rdata = RBASE + 128'd100;
        cyc();
        dram_rdata_valid = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 2'b01 || ch_rdata_valid !== 2'b01 || ch_rdata !== RBASE + 128'd100) begin
            errors++;
            $display("FAIL tag_pop_regrant: ready=%b rvalid=%b data=%h required 01 01 %h",
                     ch_ready, ch_rdata_valid, ch_rdata, RBASE + 128'd100);
        end
        cyc();
        ch_valid = 2'b00;
        cyc();
        for (int k = 0; k < 8; k++) begin
            dram_rdata_valid = 1'b1; dram_rdata = RBASE + 128'(200 + k);
            cyc();
            checks++;
            if (ch_rdata_valid !== 2'b01 || ch_rdata !== RBASE + 128'(200 + k)) begin
                errors++;
                $display("FAIL tag_drain[%0d]: rvalid=%b data=%h required 01 %h", k, ch_rdata_valid,
                         ch_rdata, RBASE + 128'(200 + k));
            end
        end
        dram_rdata_valid = 1'b0;
        cyc();
        checks++;
        if (ch_rdata_valid !== 2'b00 || err_orphan !== 1'b0) begin
            errors++; $display("FAIL tag_drain_end: rvalid=%b orphan=%b required 00 0", ch_rdata_valid, err_orphan);
        end
    endtask

    task automatic test_init_busy();
        sdram_init_busy = 1'b1; ch_valid = 2'b11; ch_write = 2'b11; dram_ready = 1'b1;
        #1;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (ch_ready !== 2'b00 || dram_valid !== 1'b0) begin
                errors++; $display("FAIL busy_no_grant[%0d]: ready=%b dvalid=%b required 00 0", k, ch_ready, dram_valid);
            end
            cyc();
        end
        sdram_init_busy = 1'b0;
        #1;
        checks++;
        if (ch_ready !== 2'b10) begin
            errors++; $display("FAIL busy_release: ch_ready=%b required 10", ch_ready);
        end
        cyc();
        sdram_init_busy = 1'b1;
        #1;
        checks++;
        if (ch_ready !== 2'b00 || dram_valid !== 1'b1 || dram_address !== A1) begin
            errors++;
            $display("FAIL busy_stage_full: ready=%b dvalid=%b addr=%h required 00 1 %h", ch_ready, dram_valid, dram_address, A1);
        end
        cyc();
        checks++;
        if (dram_valid !== 1'b0) begin
            errors++; $display("FAIL busy_drain: dvalid=%b required 0", dram_valid);
        end
        sdram_init_busy = 1'b0; ch_valid = 2'b00;
        cyc();
    endtask

    task automatic test_orphan();
        dram_rdata_valid = 1'b1; dram_rdata = RBASE + 128'd7;
        cyc();
        dram_rdata_valid = 1'b0;
        checks++;
        if (ch_rdata_valid !== 2'b00 || err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_set: rvalid=%b orphan=%b required 00 1", ch_rdata_valid, err_orphan);
        end
        repeat (3) cyc();
        checks++;
        if (err_orphan !== 1'b1) begin
            errors++; $display("FAIL orphan_sticky: orphan=%b required 1", err_orphan);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (err_orphan !== 1'b0) begin
            errors++; $display("FAIL orphan_reset_clear: orphan=%b required 0", err_orphan);
        end
        cyc();
        reset = 1'b0;
        ch_valid = 2'b01; ch_write = 2'b00; dram_ready = 1'b1;
        cyc();
        ch_valid = 2'b00;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        dram_rdata_valid = 1'b1;
        cyc();
        dram_rdata_valid = 1'b0;
        checks++;
        if (ch_rdata_valid !== 2'b00 || err_orphan !== 1'b1) begin
            errors++;
            $display("FAIL orphan_after_reset: rvalid=%b orphan=%b required 00 1", ch_rdata_valid, err_orphan);
        end
    endtask

    task automatic test_stats();
        logic [31:0] exp5;
`ifdef DRAM_ARBITER_STATS_EN
        exp5 = 32'h0000_0005;
`else
        exp5 = 32'h0000_0000;
`endif
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        ch_valid = 2'b01; ch_write = 2'b01; dram_ready = 1'b1;
        repeat (5) cyc();
        checks++;
        if (stat_req_count !== exp5) begin
            errors++; $display("FAIL stats_five: stat=%h required %h", stat_req_count, exp5);
        end
`ifdef DRAM_ARBITER_STATS_EN
        repeat (70000) cyc();
        checks++;
        if (stat_req_count !== 32'h0000_FFFF) begin
            errors++; $display("FAIL stats_saturate: stat=%h required 0000ffff", stat_req_count);
        end
`endif
        ch_valid = 2'b00;
        cyc();
    endtask

    initial begin
        reset = 1'b1; sdram_init_busy = 1'b0;
        ch_address = {A1, A0}; ch_wdata = {W1, W0}; ch_wdata_mask = {M1, M0};
        ch_write = 2'b00; ch_valid = 2'b00; dram_ready = 1'b0;
        dram_rdata = '0; dram_rdata_valid = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_tag_full();
        test_init_busy();
        test_orphan();
        test_stats();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
